beta_irq_ctrl: RTL

- Interrupt initiator for the Beta-style CPU. It collects peripheral interrupt events, applies a mask and fixed priority, and drives the IRQ input of the control unit.
- It detects when the CPU takes the interrupt by seeing PCSEL = 3'b100 while IRQ is high.
- It then holds off further requests until the CPU leaves supervisor mode.
- Sits beside the control unit and the PC register in the top level.

---
 rtl/beta_irq_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/beta_irq_ctrl.sv
// beta_irq_ctrl: interrupt initiator for the Beta-style CPU.
// Captures peripheral interrupt events into a pending register. It masks them,
// picks the lowest-index eligible source and drives a registered IRQ to the
// control unit. An acknowledge is PCSEL = 3'b100 while IRQ is high. After an
// acknowledge, further requests are held off until the CPU leaves supervisor mode.
// Optional macro BETA_IRQ_LEVEL_EN: level-sensitive sources. In that build,
// pending follows irq_src each cycle, and clears have no effect.
// Without the macro, sources are captured on their rising edge.

module beta_irq_ctrl #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = $clog2(N_SRC)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [2:0]       PCSEL,
    input  logic             PC_SUPER,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             clr_we,
    input  logic [N_SRC-1:0] clr_wdata,
    output logic             IRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_pending,
    output logic [N_SRC-1:0] irq_mask,
    output logic             in_service
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StService = 1'b1;

    localparam logic [2:0] PcselIrq = 3'b100;

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic             r_irq;
    logic [ID_W-1:0]  r_irq_id;
    logic [0:0]       r_state;

    logic [N_SRC-1:0] w_elig;
    logic             w_any;
    logic             w_ack;
    logic [ID_W-1:0]  w_enc_id;
    logic [N_SRC-1:0] w_pending_d;
    logic             w_irq_d;
    logic [ID_W-1:0]  w_irq_id_d;
    logic [0:0]       w_state_d;

    assign w_elig = r_pending & r_mask;
    assign w_any  = |w_elig;
    assign w_ack  = r_irq && (PCSEL == PcselIrq);

    // Fixed priority encoder: lowest set index of the eligible vector wins.
    always_comb begin
        w_enc_id = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_enc_id = ID_W'(i);
            end
        end
    end

`ifdef BETA_IRQ_LEVEL_EN
    // Level mode: pending simply mirrors the source lines one cycle late.
    always_comb begin
        w_pending_d = irq_src;
    end

    logic w_unused;
    assign w_unused = ^{clr_we, clr_wdata};
`else
    logic [N_SRC-1:0] r_src_prev;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_sw_clr;

    // Decode the acknowledged source into a one-hot clear vector.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            w_ack_clr[i] = w_ack && (r_irq_id == ID_W'(i));
        end
    end

    assign w_sw_clr = clr_we ? clr_wdata : '0;

    // Clear first, then set, so a fresh rise survives a same-edge clear.
    always_comb begin
        w_pending_d = (r_pending & ~w_sw_clr & ~w_ack_clr) | (irq_src & ~r_src_prev);
    end

    // Previous source sample for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_src_prev <= '0;
        end else begin
            r_src_prev <= irq_src;
        end
    end
`endif

    // Request/service FSM next-state: IRQ is recomputed each cycle in IDLE.
    always_comb begin
        w_state_d  = r_state;
        w_irq_d    = 1'b0;
        w_irq_id_d = r_irq_id;
        case (r_state)
            StIdle: begin
                if (w_ack) begin
                    w_state_d = StService;
                end else begin
                    w_irq_d = w_any && !PC_SUPER;
                    if (w_any) begin
                        w_irq_id_d = w_enc_id;
                    end
                end
            end
            StService: begin
                // Handler returns to user mode: leave service.
                if (!PC_SUPER) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State registers; reset wins over every other event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_irq     <= 1'b0;
            r_irq_id  <= '0;
            r_state   <= StIdle;
        end else begin
            r_pending <= w_pending_d;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            r_irq    <= w_irq_d;
            r_irq_id <= w_irq_id_d;
            r_state  <= w_state_d;
        end
    end

    assign IRQ         = r_irq;
    assign irq_id      = r_irq_id;
    assign irq_pending = r_pending;
    assign irq_mask    = r_mask;
    assign in_service  = (r_state == StService);

endmodule
